// File: rtl/track_scroller_pkg.sv
// rtl/track_scroller_pkg.sv - shared state encoding, LFSR taps and timer period defaults
package track_scroller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  // Taps 8,6,5,4 of x^8+x^6+x^5+x^4+1, as bit positions 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam int CFG_W         = 10;
  localparam int CFG_START_DEF = 500;
  localparam int CFG_STEP_DEF  = 25;
  localparam int CFG_MIN_DEF   = 100;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/track_scroller_if.sv
// rtl/track_scroller_if.sv - game control inputs and track/score/timer outputs of the scroller
interface track_scroller_if #(
  parameter int TRACK_LEN = 8,
  parameter int SCORE_W   = 10
);

  logic                 Start;
  logic                 Tick;
  logic                 PlayerHigh;
  logic [TRACK_LEN-1:0] TrackLow;
  logic [TRACK_LEN-1:0] TrackHigh;
  logic [SCORE_W-1:0]   Score;
  logic [9:0]           CfgOut;
  logic                 TimerClear;
  logic                 Running;
  logic                 GameOver;

  modport master (
    output Start, Tick, PlayerHigh,
    input  TrackLow, TrackHigh, Score, CfgOut, TimerClear, Running, GameOver
  );

  modport slave (
    input  Start, Tick, PlayerHigh,
    output TrackLow, TrackHigh, Score, CfgOut, TimerClear, Running, GameOver
  );

endinterface

// File: rtl/track_scroller_lfsr8.sv
// rtl/track_scroller_lfsr8.sv - free-running 8-bit Fibonacci LFSR, reloaded only by reset
module lfsr8
  import track_scroller_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       Clk,
  input  logic       Rst,
  output logic [7:0] state
);

  logic [7:0] state_q, state_d;

  always_comb state_d = lfsr_next(state_q);

  always_ff @(posedge Clk) begin
    if (!Rst) state_q <= SEED;
    else      state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/track_scroller.sv
// rtl/track_scroller.sv - two-lane obstacle track, collision, score and timer speed-up
module track_scroller
  import track_scroller_pkg::*;
#(
  parameter int         TRACK_LEN  = 8,
  parameter int         GAP_MIN    = 2,
  parameter int         SCORE_W    = 10,
  parameter int         CFG_START  = CFG_START_DEF,
  parameter int         CFG_STEP   = CFG_STEP_DEF,
  parameter int         CFG_MIN    = CFG_MIN_DEF,
  parameter int         SCORE_STEP = 8,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input logic              Clk,
  input logic              Rst,
  track_scroller_if.slave  bus
);

  localparam int GAP_W = $clog2(GAP_MIN + 1);
  localparam logic [GAP_W-1:0]   GAP_MIN_V   = GAP_W'(GAP_MIN);
  localparam logic [GAP_W-1:0]   GAP_ONE     = GAP_W'(1);
  localparam logic [SCORE_W-1:0] SCORE_MAX   = '1;
  localparam logic [SCORE_W-1:0] SCORE_ONE   = SCORE_W'(1);
  localparam logic [CFG_W-1:0]   CFG_START_V = CFG_W'(CFG_START);
  localparam logic [CFG_W-1:0]   CFG_STEP_V  = CFG_W'(CFG_STEP);
  localparam logic [CFG_W-1:0]   CFG_MIN_V   = CFG_W'(CFG_MIN);
  localparam logic [CFG_W-1:0]   CFG_FLOOR_V = CFG_W'(CFG_MIN + CFG_STEP);

  state_e               state_q, state_d;
  logic [TRACK_LEN-1:0] low_q, low_d, high_q, high_d;
  logic [SCORE_W-1:0]   score_q, score_d, score_inc;
  logic [CFG_W-1:0]     cfg_q, cfg_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic                 tclr_q, tclr_d;
  logic                 running_q, running_d, over_q, over_d;
  logic                 collision, passed, spawn;
  logic [7:0]           lfsr;
  logic                 lfsr_unused;

  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .Clk   (Clk),
    .Rst   (Rst),
    .state (lfsr)
  );

  // Only the low three bits steer spawning; the rest just feed the shift
  assign lfsr_unused = ^lfsr[7:3];

  always_comb begin
    state_d   = state_q;
    low_d     = low_q;
    high_d    = high_q;
    score_d   = score_q;
    cfg_d     = cfg_q;
    gap_d     = gap_q;
    tclr_d    = 1'b0;
    collision = (low_q[0] & ~bus.PlayerHigh) | (high_q[0] & bus.PlayerHigh);
    passed    = low_q[0] | high_q[0];
    spawn     = (gap_q >= GAP_MIN_V) && (lfsr[1:0] == 2'b00);
    score_inc = score_q + SCORE_ONE;

    if (bus.Start) begin
      state_d = ST_RUN;
      low_d   = '0;
      high_d  = '0;
      score_d = '0;
      gap_d   = '0;
      cfg_d   = CFG_START_V;
      tclr_d  = 1'b1;
    end else if (state_q == ST_RUN) begin
      if (collision) begin
        state_d = ST_OVER;
      end else if (bus.Tick) begin
        low_d  = low_q >> 1;
        high_d = high_q >> 1;
        if (spawn) begin
          low_d[TRACK_LEN-1]  = ~lfsr[2];
          high_d[TRACK_LEN-1] = lfsr[2];
          gap_d               = '0;
        end else if (gap_q < GAP_MIN_V) begin
          gap_d = gap_q + GAP_ONE;
        end
        // Saturated score neither increments nor speeds the timer up
        if (passed && (score_q != SCORE_MAX)) begin
          score_d = score_inc;
          if ((int'(score_inc) % SCORE_STEP) == 0)
            cfg_d = (cfg_q >= CFG_FLOOR_V) ? (cfg_q - CFG_STEP_V) : CFG_MIN_V;
        end
      end
    end

    running_d = (state_d == ST_RUN);
    over_d    = (state_d == ST_OVER);
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q   <= ST_IDLE;
      low_q     <= '0;
      high_q    <= '0;
      score_q   <= '0;
      cfg_q     <= CFG_START_V;
      gap_q     <= '0;
      tclr_q    <= 1'b0;
      running_q <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      low_q     <= low_d;
      high_q    <= high_d;
      score_q   <= score_d;
      cfg_q     <= cfg_d;
      gap_q     <= gap_d;
      tclr_q    <= tclr_d;
      running_q <= running_d;
      over_q    <= over_d;
    end
  end

  assign bus.TrackLow   = low_q;
  assign bus.TrackHigh  = high_q;
  assign bus.Score      = score_q;
  assign bus.CfgOut     = cfg_q;
  assign bus.TimerClear = tclr_q;
  assign bus.Running    = running_q;
  assign bus.GameOver   = over_q;

endmodule

// File: tb/tb_track_scroller.sv
// tb/tb_track_scroller.sv - randomized bench for track_scroller against a game-rules model
module tb_track_scroller;

  localparam int TL         = 8;
  localparam int SW         = 10;
  localparam int GAP_MIN    = 2;
  localparam int SCORE_MAX  = 1023;
  localparam int SCORE_STEP = 8;
  localparam int CFG_START  = 500;
  localparam int CFG_STEP   = 25;
  localparam int CFG_MIN    = 100;
  localparam int M_IDLE = 0, M_RUN = 1, M_OVER = 2;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  always #5 Clk = ~Clk;

  track_scroller_if #(.TRACK_LEN(TL), .SCORE_W(SW)) bus();

  track_scroller #(.TRACK_LEN(TL), .SCORE_W(SW)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Game model: column arrays per lane, played by the rules
  int m_st, m_score, m_cfg, m_gap, m_tclr, m_lfsr;
  bit m_lo[TL];
  bit m_hi[TL];

  function automatic int lfsr_after(input int s);
    int fb;
    fb = ((s >> 7) ^ (s >> 5) ^ (s >> 4) ^ (s >> 3)) & 1;
    return ((s << 1) | fb) & 255;
  endfunction

  function automatic int lane_bits(input bit hi);
    int v = 0;
    for (int i = 0; i < TL; i++)
      if (hi ? m_hi[i] : m_lo[i]) v |= (1 << i);
    return v;
  endfunction

  function automatic bit safe_ph();
    if (m_lo[0]) return 1'b1;
    if (m_hi[0]) return 1'b0;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic model_update(input bit start, input bit tick, input bit ph, input bit rstn);
    int  nl;
    bit  passed;
    if (!rstn) begin
      m_st = M_IDLE; m_score = 0; m_cfg = CFG_START; m_gap = 0; m_tclr = 0; m_lfsr = 8'hA5;
      for (int i = 0; i < TL; i++) begin m_lo[i] = 0; m_hi[i] = 0; end
      return;
    end
    nl = lfsr_after(m_lfsr);
    m_tclr = 0;
    if (start) begin
      m_st = M_RUN; m_score = 0; m_cfg = CFG_START; m_gap = 0; m_tclr = 1;
      for (int i = 0; i < TL; i++) begin m_lo[i] = 0; m_hi[i] = 0; end
    end else if (m_st == M_RUN) begin
      if ((m_lo[0] && !ph) || (m_hi[0] && ph)) begin
        m_st = M_OVER;
      end else if (tick) begin
        passed = m_lo[0] || m_hi[0];
        for (int i = 0; i < TL - 1; i++) begin m_lo[i] = m_lo[i+1]; m_hi[i] = m_hi[i+1]; end
        m_lo[TL-1] = 0;
        m_hi[TL-1] = 0;
        if (m_gap >= GAP_MIN && (m_lfsr % 4) == 0) begin
          if ((m_lfsr / 4) % 2 == 1) m_hi[TL-1] = 1;
          else                       m_lo[TL-1] = 1;
          m_gap = 0;
        end else if (m_gap < GAP_MIN) begin
          m_gap++;
        end
        if (passed && m_score < SCORE_MAX) begin
          m_score++;
          if (m_score % SCORE_STEP == 0)
            m_cfg = (m_cfg - CFG_STEP < CFG_MIN) ? CFG_MIN : m_cfg - CFG_STEP;
        end
      end
    end
    m_lfsr = nl;
  endtask

  task automatic step(input bit start, input bit tick, input bit ph, input bit rstn);
    int occ, viol;
    bus.Start = start; bus.Tick = tick; bus.PlayerHigh = ph; Rst = rstn;
    model_update(start, tick, ph, rstn);
    @(posedge Clk);
    #1;
    check("TrackLow",   bus.TrackLow,   lane_bits(1'b0));
    check("TrackHigh",  bus.TrackHigh,  lane_bits(1'b1));
    check("Score",      bus.Score,      m_score);
    check("CfgOut",     bus.CfgOut,     m_cfg);
    check("TimerClear", bus.TimerClear, m_tclr);
    check("Running",    bus.Running,    m_st == M_RUN);
    check("GameOver",   bus.GameOver,   m_st == M_OVER);
    occ  = int'(bus.TrackLow | bus.TrackHigh);
    viol = 0;
    for (int i = 0; i < TL; i++)
      for (int d = 1; d <= GAP_MIN && i + d < TL; d++)
        if (((occ >> i) & 1) && ((occ >> (i + d)) & 1)) viol++;
    check("spacing",      viol, 0);
    check("lane_overlap", bus.TrackLow & bus.TrackHigh, 0);
    bus.Start = 1'b0; bus.Tick = 1'b0; Rst = 1'b1;
  endtask

  task automatic play_until(input int target, input int budget);
    int n = 0;
    while (m_score < target && n < budget) begin
      step(1'b0, $urandom_range(0, 3) != 0, safe_ph(), 1'b1);
      n++;
    end
    check("reach_score", bus.Score, target);
  endtask

  int  saved_lo, saved_hi, saved_score;
  bit  found, got_clear, t;

  initial begin
    bus.Start = 1'b0; bus.Tick = 1'b0; bus.PlayerHigh = 1'b0;

    // Reset state
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("rst_cfg", bus.CfgOut, 500);
    check("rst_run", bus.Running, 0);
    check("rst_trk", bus.TrackLow | bus.TrackHigh, 0);
    step(1'b0, 1'b1, 1'b0, 1'b1);

    // Start together with Tick in IDLE
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("start_tclr", bus.TimerClear, 1);
    check("start_running", bus.Running, 1);
    check("start_noshift", bus.TrackLow | bus.TrackHigh, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("tclr_one_cycle", bus.TimerClear, 0);

    // Twenty dodged ticks
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, safe_ph(), 1'b1);

    // Start+Tick mid-run clears everything
    step(1'b1, 1'b1, safe_ph(), 1'b1);
    check("restart_trk", bus.TrackLow | bus.TrackHigh, 0);
    check("restart_score", bus.Score, 0);

    // Reset mid-run at score 5
    play_until(5, 2000);
    step(1'b0, 1'b1, safe_ph(), 1'b0);
    check("midrst_score", bus.Score, 0);
    check("midrst_cfg", bus.CfgOut, 500);
    check("midrst_run", bus.Running, 0);
    step(1'b1, 1'b0, 1'b0, 1'b1);

    // Speed-up steps and floor
    play_until(8, 2000);
    check("cfg_at_8", bus.CfgOut, 475);
    play_until(128, 20000);
    check("cfg_at_128", bus.CfgOut, 100);
    play_until(136, 2000);
    check("cfg_at_136", bus.CfgOut, 100);

    // Collision with a low obstacle, Tick in the same cycle
    found = 1'b0;
    for (int c = 0; c < 500 && !found; c++) begin
      if (m_lo[0] && m_st == M_RUN) found = 1'b1;
      else step(1'b0, $urandom_range(0, 1) == 1, safe_ph(), 1'b1);
    end
    check("low_at_col0", found, 1);
    saved_lo = int'(bus.TrackLow); saved_hi = int'(bus.TrackHigh); saved_score = int'(bus.Score);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check("coll_over", bus.GameOver, 1);
    check("coll_noshift_lo", bus.TrackLow, saved_lo);
    check("coll_noshift_hi", bus.TrackHigh, saved_hi);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b1);
    check("over_frozen_lo", bus.TrackLow, saved_lo);
    check("over_frozen_score", bus.Score, saved_score);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("over_restart_run", bus.Running, 1);
    check("over_restart_score", bus.Score, 0);
    check("over_restart_cfg", bus.CfgOut, 500);
    check("over_restart_trk", bus.TrackLow | bus.TrackHigh, 0);

    // Saturation at 1023
    play_until(1023, 40000);
    got_clear = 1'b0;
    for (int c = 0; c < 300 && !got_clear; c++) begin
      t = 1'($urandom_range(0, 1));
      if (t && (m_lo[0] || m_hi[0])) got_clear = 1'b1;
      step(1'b0, t, safe_ph(), 1'b1);
    end
    check("sat_clear_seen", got_clear, 1);
    check("sat_score", bus.Score, 1023);
    check("sat_cfg", bus.CfgOut, 100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/track_scroller.md
Name: track_scroller

Overview:
Game-field engine driven by the periodic Tick of the configurable ms timer.
- Scrolls a two-lane obstacle track one column toward the player on each Tick, spawning new obstacles pseudo-randomly.
- Detects player collisions and counts cleared obstacles.
- Feeds a shrinking period value back to the timer, so the game speeds up with score.
- Sits between the timer and the seven-segment display encoder.

Parameters:
TRACK_LEN, 8, number of track columns; column 0 is the player column.
GAP_MIN, 2, minimum number of empty columns between spawned obstacles.
SCORE_W, 10, score width; the score saturates at all-ones.
CFG_START, 500, timer period value loaded on Rst and on every Start.
CFG_STEP, 25, amount subtracted from CfgOut at each speed-up.
CFG_MIN, 100, floor for CfgOut.
SCORE_STEP, 8, a speed-up occurs each time the score reaches a multiple of this value.
LFSR_SEED, 8'hA5, nonzero LFSR reset value.

Ports:
Clk  in  1  clock
Rst  in  1  synchronous, active-low reset
Start  in  1  single-cycle pulse; begins or restarts a game
Tick  in  1  single-cycle scroll strobe from the timer
PlayerHigh  in  1  player lane: 1 = high, 0 = low
TrackLow  out  TRACK_LEN  low-lane obstacle bitmap; bit 0 = player column
TrackHigh  out  TRACK_LEN  high-lane obstacle bitmap
Score  out  SCORE_W  count of cleared obstacles
CfgOut  out  10  period value driven to the timer's CfgValue
TimerClear  out  1  one-cycle pulse to the timer's Clear input
Running  out  1  high in RUN
GameOver  out  1  high in OVER

Behaviour:
- Reset: on Clk edge with Rst=0 → state IDLE, TrackLow=TrackHigh=0, Score=0, CfgOut=CFG_START, TimerClear=0, gap counter=0, LFSR=LFSR_SEED. Rst has priority over every other input in any state.
- All outputs are registered.
- States (IDLE, RUN, OVER):
  - IDLE: track held at 0. Start → RUN. Tick ignored.
  - RUN: Running=1. Collision → OVER. Start restarts the game (same clearing actions as an IDLE→RUN Start).
  - OVER: GameOver=1. Track, Score and CfgOut are frozen; Tick ignored. Start → RUN.
- On Start (any non-reset state), in the same edge:
  - clear track, Score and gap counter;
  - CfgOut=CFG_START;
  - TimerClear=1 for exactly the next cycle.
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4; shifts every clock in all states.
  - It is never reloaded except by Rst, so games differ from each other.
- Collision term: col0 occupied in the player's lane, i.e. (TrackLow[0] & ~PlayerHigh) | (TrackHigh[0] & PlayerHigh). It is evaluated every cycle in RUN on the registered track and the current PlayerHigh.
- RUN, in priority order:
  1. Start.
  2. Collision → OVER next cycle. No shift, no score change, even if Tick is high that cycle.
  3. Tick → scroll for one cycle:
     - Track[i] ← Track[i+1] for i < TRACK_LEN-1.
     - Top column gets a spawn when gap ≥ GAP_MIN and LFSR[1:0]==0. Lane is high if LFSR[2]=1, else low; the spawn fills exactly one lane. Then gap ← 0.
     - Otherwise top column ← 0 and gap increments, saturating at GAP_MIN.
     - If the old col0 was occupied, Score increments (saturating).
- Speed-up: when an increment makes the new Score a nonzero multiple of SCORE_STEP, CfgOut ← max(CfgOut−CFG_STEP, CFG_MIN) in the same edge. A saturated Score does not trigger a speed-up.
- Latency: Tick → updated track visible next cycle. Collision → GameOver next cycle.
- Simultaneous Start and Tick in any state: Start wins and Tick is dropped.

Decomposition:
- Shared package: state encoding (IDLE, RUN, OVER), LFSR tap mask, and CFG_START/CFG_MIN/CFG_STEP defaults shared with the timer instantiation.
- One sub-module, lfsr8 (Clk, Rst, seed parameter, 8-bit state output).
- Score/speed logic and track shifter stay inline.

Test Plan:
1. Reset → TrackLow=TrackHigh=0, Score=0, CfgOut=500, Running=0, GameOver=0. Apply Rst=0 mid-RUN with Score=5 → same values next cycle.
2. IDLE, Start pulse → Running=1 and TimerClear=1 for exactly 1 cycle. Start+Tick together in IDLE → no shift on that edge.
3. RUN, 20 Ticks with PlayerHigh always matching the non-obstacle lane at col0 → tracks match the reference model from the LFSR sequence; spacing between obstacles ≥ GAP_MIN empty columns; Score = obstacles passed.
4. Clear 8 obstacles → CfgOut=475 on the edge Score becomes 8. Preload/clear 128 → CfgOut=100 and it stays at 100 at Score=136.
5. Low obstacle reaches col0 with PlayerHigh=0 → GameOver=1 next cycle. A Tick in the collision cycle causes no shift. Further Ticks leave track and Score frozen. Start → RUN, track cleared, Score=0, CfgOut=500.
6. Score forced to 1023 → a further clear keeps 1023 and causes no CfgOut change.
